// File: rtl/aqp_ebus_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aqp_ebus_uart_pkg
//  Purpose  : Shared constants for the ebus UART I/O responder: port offsets
//             (selected by ebus_a[0]), status byte bit positions and control
//             byte bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package aqp_ebus_uart_pkg;

    // Port offsets, selected by ebus_a[0]
    localparam logic c_PORT_CTRL = 1'b0;    // status on read, control on write
    localparam logic c_PORT_DATA = 1'b1;    // RX head on read, TX push on write

    // Status byte bit positions
    localparam int unsigned c_ST_RX_NOT_EMPTY = 0;
    localparam int unsigned c_ST_TX_FULL      = 1;
    localparam int unsigned c_ST_OVERFLOW     = 2;
    localparam int unsigned c_ST_FRAMING      = 3;
    localparam int unsigned c_ST_IRQ_EN       = 4;
    localparam int unsigned c_ST_TX_SOF       = 5;
    localparam int unsigned c_ST_TX_OVERRUN   = 6;
    localparam int unsigned c_ST_RX_SOF       = 7;

    // Control byte bit positions
    localparam int unsigned c_CTL_CLR_OVERFLOW = 0;
    localparam int unsigned c_CTL_CLR_FRAMING  = 1;
    localparam int unsigned c_CTL_IRQ_EN       = 4;
    localparam int unsigned c_CTL_SET_SOF      = 5;
    localparam int unsigned c_CTL_CLR_OVERRUN  = 6;

endpackage : aqp_ebus_uart_pkg
`default_nettype wire

// File: rtl/aqp_ebus_strobe_sync.sv
`default_nettype none
// ============================================================================
//  Module   : aqp_ebus_strobe_sync
//  Purpose  : Synchronizes one active-low bus strobe and produces single-clock
//             fall/rise indications. Depth is 2 stages when the internal T80
//             drives the bus, 3 stages for the external Z80.
//  Ports    : clk, reset_n      - clock, async active-low reset
//             i_use_t80         - 1 = detect on q[1:0], 0 = detect on q[2:1]
//             i_strobe_n        - raw strobe pin
//             o_fall / o_rise   - combinational edge indications
//  Revision : 1.0  initial release
// ============================================================================
module aqp_ebus_strobe_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_use_t80,
    input  logic i_strobe_n,
    output logic o_fall,
    output logic o_rise
);

    // r_q[0] is the newest sample. Presetting to all-ones means a strobe that
    // is already high when reset releases never looks like a rising edge.
    logic [2:0] r_q;
    logic [1:0] w_pair;     // {older, newer}

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 3'b111;
        end else begin
            r_q <= {r_q[1:0], i_strobe_n};
        end
    end

    assign w_pair = i_use_t80 ? r_q[1:0] : r_q[2:1];
    assign o_fall = (w_pair == 2'b10);
    assign o_rise = (w_pair == 2'b01);

endmodule : aqp_ebus_strobe_sync
`default_nettype wire

// File: rtl/aqp_ebus_uart_port.sv
`default_nettype none
// ============================================================================
//  Module   : aqp_ebus_uart_port
//  Purpose  : Z80 I/O responder exposing the ESP32 UART FIFOs as two ports
//             (BASE_PORT+0 status/control, BASE_PORT+1 data). Completed bus
//             cycles become single-clock FIFO push/pop strobes.
//  Ports    : clk, reset_n               - clock, async active-low reset
//             use_t80                    - initiator select (sync depth)
//             ebus_a/d/rd_n/wr_n/iorq_n  - raw external bus pins
//             ebus_d_out, ebus_d_oe      - read data and drive enable
//             irq_n                      - registered interrupt request
//             txfifo_*                   - TX FIFO push side
//             rxfifo_*                   - RX FIFO pop side
//             rxfifo_overflow, rx_framing_error - error pulses
//  Revision : 1.0  initial release
// ============================================================================
module aqp_ebus_uart_port
    import aqp_ebus_uart_pkg::*;
#(
    parameter logic [7:0] BASE_PORT = 8'hF4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       use_t80,
    input  logic [7:0] ebus_a,
    input  logic [7:0] ebus_d,
    input  logic       ebus_rd_n,
    input  logic       ebus_wr_n,
    input  logic       ebus_iorq_n,
    output logic [7:0] ebus_d_out,
    output logic       ebus_d_oe,
    output logic       irq_n,
    output logic [8:0] txfifo_data,
    output logic       txfifo_wr,
    input  logic       txfifo_full,
    input  logic [8:0] rxfifo_data,
    output logic       rxfifo_rd,
    input  logic       rxfifo_empty,
    input  logic       rxfifo_overflow,
    input  logic       rx_framing_error
);

    logic       w_sel;
    logic       w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
    logic       w_wr_commit, w_ctl_wr, w_data_wr;
    logic [7:0] w_status;

    logic       r_cyc_sel, r_cyc_port;
    logic [7:0] r_wr_data;
    logic [8:0] r_txfifo_data;
    logic       r_txfifo_wr, r_rxfifo_rd, r_irq_n;
    logic       r_overflow, r_framing, r_tx_overrun, r_tx_sof, r_irq_en;

    aqp_ebus_strobe_sync u_rd_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_use_t80  (use_t80),
        .i_strobe_n (ebus_rd_n),
        .o_fall     (w_rd_fall),
        .o_rise     (w_rd_rise)
    );

    aqp_ebus_strobe_sync u_wr_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_use_t80  (use_t80),
        .i_strobe_n (ebus_wr_n),
        .o_fall     (w_wr_fall),
        .o_rise     (w_wr_rise)
    );

    assign w_sel = !ebus_iorq_n && (ebus_a[7:1] == BASE_PORT[7:1]);

    // Drive enable comes straight from the pins so read data is on the bus
    // well before the CPU samples it, independent of the sync latency.
    assign ebus_d_oe = reset_n && w_sel && !ebus_rd_n;

    always_comb begin
        w_status                    = 8'h00;
        w_status[c_ST_RX_NOT_EMPTY] = !rxfifo_empty;
        w_status[c_ST_TX_FULL]      = txfifo_full;
        w_status[c_ST_OVERFLOW]     = r_overflow;
        w_status[c_ST_FRAMING]      = r_framing;
        w_status[c_ST_IRQ_EN]       = r_irq_en;
        w_status[c_ST_TX_SOF]       = r_tx_sof;
        w_status[c_ST_TX_OVERRUN]   = r_tx_overrun;
        w_status[c_ST_RX_SOF]       = rxfifo_data[8];
    end

    assign ebus_d_out = (ebus_a[0] == c_PORT_DATA)
                      ? (rxfifo_empty ? 8'h00 : rxfifo_data[7:0])
                      : w_status;

    // Commits use the address latched at the falling edge: the CPU may have
    // moved the address on by the time the synchronized rising edge arrives.
    assign w_wr_commit = w_wr_rise && r_cyc_sel;
    assign w_ctl_wr    = w_wr_commit && (r_cyc_port == c_PORT_CTRL);
    assign w_data_wr   = w_wr_commit && (r_cyc_port == c_PORT_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_sel     <= 1'b0;
            r_cyc_port    <= 1'b0;
            r_wr_data     <= 8'h00;
            r_txfifo_data <= 9'h000;
            r_txfifo_wr   <= 1'b0;
            r_rxfifo_rd   <= 1'b0;
            r_irq_n       <= 1'b1;
            r_overflow    <= 1'b0;
            r_framing     <= 1'b0;
            r_tx_overrun  <= 1'b0;
            r_tx_sof      <= 1'b0;
            r_irq_en      <= 1'b0;
        end else begin
            r_txfifo_wr <= 1'b0;
            r_rxfifo_rd <= 1'b0;

            if (w_rd_fall || w_wr_fall) begin
                r_cyc_sel  <= w_sel;
                r_cyc_port <= ebus_a[0];
            end

            // Track the raw data pins for the whole write strobe so the last
            // stable value is what gets committed.
            if (!ebus_wr_n) begin
                r_wr_data <= ebus_d;
            end

            if (w_rd_rise && r_cyc_sel && (r_cyc_port == c_PORT_DATA) && !rxfifo_empty) begin
                r_rxfifo_rd <= 1'b1;
            end

            if (w_data_wr) begin
                if (!txfifo_full) begin
                    r_txfifo_data <= {r_tx_sof, r_wr_data};
                    r_txfifo_wr   <= 1'b1;
                    r_tx_sof      <= 1'b0;
                end else begin
                    r_tx_overrun  <= 1'b1;
                end
            end

            if (w_ctl_wr) begin
                r_irq_en <= r_wr_data[c_CTL_IRQ_EN];
                if (r_wr_data[c_CTL_CLR_OVERRUN]) begin
                    r_tx_overrun <= 1'b0;
                end
                if (r_wr_data[c_CTL_SET_SOF]) begin
                    r_tx_sof <= 1'b1;
                end
            end

            // Set has priority so an error arriving during a clear is not lost.
            r_overflow <= rxfifo_overflow ||
                          (r_overflow && !(w_ctl_wr && r_wr_data[c_CTL_CLR_OVERFLOW]));
            r_framing  <= rx_framing_error ||
                          (r_framing && !(w_ctl_wr && r_wr_data[c_CTL_CLR_FRAMING]));

            r_irq_n <= !(r_irq_en && (!rxfifo_empty || r_overflow));
        end
    end

    assign txfifo_data = r_txfifo_data;
    assign txfifo_wr   = r_txfifo_wr;
    assign rxfifo_rd   = r_rxfifo_rd;
    assign irq_n       = r_irq_n;

endmodule : aqp_ebus_uart_port
`default_nettype wire

// File: tb/tb_aqp_ebus_uart_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aqp_ebus_uart_port
//  Purpose  : Directed self-checking bench for aqp_ebus_uart_port. Expected
//             TX pushes are queued when a data-port write is issued and
//             compared when txfifo_wr pulses; RX pops are counted against
//             an expected count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aqp_ebus_uart_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       use_t80;
    logic [7:0] ebus_a, ebus_d;
    logic       ebus_rd_n, ebus_wr_n, ebus_iorq_n;
    logic [7:0] ebus_d_out;
    logic       ebus_d_oe, irq_n;
    logic [8:0] txfifo_data;
    logic       txfifo_wr, txfifo_full;
    logic [8:0] rxfifo_data;
    logic       rxfifo_rd, rxfifo_empty, rxfifo_overflow, rx_framing_error;

    int errors    = 0;
    int checks    = 0;
    int rx_pops   = 0;
    int exp_pops  = 0;
    logic [8:0] exp_q[$];

    logic [7:0] rd_d;
    logic       rd_oe;

    always #5 clk = ~clk;

    aqp_ebus_uart_port #(.BASE_PORT(8'hF4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .use_t80          (use_t80),
        .ebus_a           (ebus_a),
        .ebus_d           (ebus_d),
        .ebus_rd_n        (ebus_rd_n),
        .ebus_wr_n        (ebus_wr_n),
        .ebus_iorq_n      (ebus_iorq_n),
        .ebus_d_out       (ebus_d_out),
        .ebus_d_oe        (ebus_d_oe),
        .irq_n            (irq_n),
        .txfifo_data      (txfifo_data),
        .txfifo_wr        (txfifo_wr),
        .txfifo_full      (txfifo_full),
        .rxfifo_data      (rxfifo_data),
        .rxfifo_rd        (rxfifo_rd),
        .rxfifo_empty     (rxfifo_empty),
        .rxfifo_overflow  (rxfifo_overflow),
        .rx_framing_error (rx_framing_error)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        ebus_a = a; ebus_d = d; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (4) wait_clk();
        ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) wait_clk();
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        ebus_a = a; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (4) wait_clk();
        d  = ebus_d_out;
        oe = ebus_d_oe;
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) wait_clk();
    endtask

    task automatic rd_status(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        io_rd(8'hF4, d, oe);
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    // Scoreboard side: every push must have been announced in the queue.
    always @(negedge clk) begin
        if (rxfifo_rd === 1'b1) rx_pops++;
        if (txfifo_wr === 1'b1) begin
            check("tx_push_expected", {15'd0, exp_q.size() != 0}, 16'd1);
            if (exp_q.size() != 0) begin
                check("tx_push_data", {7'd0, txfifo_data}, {7'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; use_t80 = 1'b1;
        ebus_a = 8'h00; ebus_d = 8'h00;
        ebus_rd_n = 1'b1; ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        txfifo_full = 1'b0; rxfifo_data = 9'h000; rxfifo_empty = 1'b1;
        rxfifo_overflow = 1'b0; rx_framing_error = 1'b0;

        // Reset state
        repeat (3) wait_clk();
        check("rst_txfifo_wr", txfifo_wr, 0);
        check("rst_rxfifo_rd", rxfifo_rd, 0);
        check("rst_irq_n", irq_n, 1);
        check("rst_txfifo_data", txfifo_data, 0);
        ebus_a = 8'hF4; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        #1;
        check("rst_d_oe_blocked", ebus_d_oe, 0);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        wait_clk();
        reset_n = 1'b1;
        repeat (2) wait_clk();

        io_rd(8'hF4, rd_d, rd_oe);
        check("status_after_reset", rd_d, 8'h00);
        check("status_read_oe", rd_oe, 1);

        // TX push latency in T80 mode: strobe 2 clk after WR# rises
        exp_q.push_back(9'h041);
        ebus_a = 8'hF5; ebus_d = 8'h41; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (4) wait_clk();
        ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        wait_clk();
        check("tx_lat_1clk", txfifo_wr, 0);
        wait_clk();
        check("tx_lat_2clk", txfifo_wr, 1);
        check("tx_data_041", txfifo_data, 9'h041);
        wait_clk();
        check("tx_pulse_width", txfifo_wr, 0);
        repeat (3) wait_clk();

        // Start-of-frame marking
        io_wr(8'hF4, 8'h20);
        rd_status("status_sof_set", 8'h20);
        exp_q.push_back(9'h17E);
        io_wr(8'hF5, 8'h7E);
        exp_q.push_back(9'h001);
        io_wr(8'hF5, 8'h01);
        check("tx_data_hold", txfifo_data, 9'h001);
        rd_status("status_sof_cleared", 8'h00);

        // RX pop, T80 mode
        rxfifo_data = 9'h1AB; rxfifo_empty = 1'b0;
        exp_pops++;
        io_rd(8'hF5, rd_d, rd_oe);
        check("rx_data_AB", rd_d, 8'hAB);
        check("rx_data_oe", rd_oe, 1);
        rd_status("status_rx_head", 8'h81);
        check("rx_pop_count_t80", rx_pops, exp_pops);

        // RX pop latency in Z80 mode: 3 clk after RD# rises
        use_t80 = 1'b0;
        exp_pops++;
        ebus_a = 8'hF5; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (5) wait_clk();
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (2) wait_clk();
        check("rx_lat_2clk", rxfifo_rd, 0);
        wait_clk();
        check("rx_lat_3clk", rxfifo_rd, 1);
        wait_clk();
        check("rx_pulse_width", rxfifo_rd, 0);
        repeat (3) wait_clk();
        use_t80 = 1'b1;
        check("rx_pop_count_z80", rx_pops, exp_pops);

        // Data read of an empty FIFO: zero data, no pop
        rxfifo_empty = 1'b1;
        io_rd(8'hF5, rd_d, rd_oe);
        check("rx_empty_data", rd_d, 8'h00);
        check("rx_empty_no_pop", rx_pops, exp_pops);

        // TX overrun
        rxfifo_data = 9'h000;
        txfifo_full = 1'b1;
        io_wr(8'hF5, 8'h55);
        rd_status("status_overrun", 8'h42);
        io_wr(8'hF4, 8'h40);
        rd_status("status_overrun_clr_full", 8'h02);
        txfifo_full = 1'b0;
        io_wr(8'hF4, 8'h20);
        txfifo_full = 1'b1;
        io_wr(8'hF5, 8'h55);
        rd_status("status_overrun_keeps_sof", 8'h62);
        txfifo_full = 1'b0;
        io_wr(8'hF4, 8'h40);
        rd_status("status_sof_survives", 8'h20);
        exp_q.push_back(9'h133);
        io_wr(8'hF5, 8'h33);
        rd_status("status_after_sof_push", 8'h00);

        // Interrupt on RX not empty
        io_wr(8'hF4, 8'h10);
        check("irq_idle", irq_n, 1);
        rxfifo_empty = 1'b0;
        check("irq_same_clk", irq_n, 1);
        wait_clk();
        check("irq_fall_1clk", irq_n, 0);
        rxfifo_empty = 1'b1;
        wait_clk();
        check("irq_release", irq_n, 1);

        // Overflow sticky and interrupt
        rxfifo_overflow = 1'b1; wait_clk(); rxfifo_overflow = 1'b0;
        wait_clk();
        check("irq_overflow", irq_n, 0);
        rd_status("status_overflow", 8'h14);

        // Clear in the same clk as a new overflow pulse: set wins
        ebus_a = 8'hF4; ebus_d = 8'h01; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (4) wait_clk();
        ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        wait_clk();
        rxfifo_overflow = 1'b1; wait_clk(); rxfifo_overflow = 1'b0;
        repeat (3) wait_clk();
        rd_status("overflow_set_wins", 8'h04);
        check("irq_disabled", irq_n, 1);
        io_wr(8'hF4, 8'h01);
        rd_status("overflow_cleared", 8'h00);

        // Framing sticky and clear
        rx_framing_error = 1'b1; wait_clk(); rx_framing_error = 1'b0;
        wait_clk();
        rd_status("status_framing", 8'h08);
        io_wr(8'hF4, 8'h02);
        rd_status("framing_cleared", 8'h00);

        // Address gone before RD# rises: latched selection still pops
        rxfifo_empty = 1'b0; rxfifo_data = 9'h0CD;
        exp_pops++;
        ebus_a = 8'hF5; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (4) wait_clk();
        check("rx_data_CD", ebus_d_out, 8'hCD);
        ebus_a = 8'h00;
        #1;
        check("oe_addr_gone", ebus_d_oe, 0);
        wait_clk();
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) wait_clk();
        check("pop_latched_addr", rx_pops, exp_pops);

        // Unselected port
        ebus_a = 8'hF6; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (4) wait_clk();
        check("oe_port_f6", ebus_d_oe, 0);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) wait_clk();
        check("no_pop_port_f6", rx_pops, exp_pops);

        // Reset in the middle of a read: no commit afterwards
        ebus_a = 8'hF5; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (4) wait_clk();
        check("oe_before_reset", ebus_d_oe, 1);
        reset_n = 1'b0;
        #1;
        check("oe_in_reset", ebus_d_oe, 0);
        wait_clk();
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (2) wait_clk();
        reset_n = 1'b1;
        repeat (6) wait_clk();
        check("no_pop_after_reset", rx_pops, exp_pops);
        check("irq_after_reset", irq_n, 1);

        check("tx_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aqp_ebus_uart_port
`default_nettype wire
